// File: rtl/viterbi_pkg.sv
// Shared types and default sizing for the Viterbi frame sequencer.
package viterbi_pkg;

  localparam int VIT_FRAME_LEN = 16;
  localparam int VIT_SIZE_DATA = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACS,
    TRACE,
    DONE
  } vit_state_t;

endpackage

// File: rtl/viterbi_step_cnt.sv
// Loadable up/down counter with enable and a terminal-count compare.
module viterbi_step_cnt #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  logic              up,
  input  logic [ADDR_W-1:0] term,
  output logic [ADDR_W-1:0] cnt,
  output logic              tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= up ? cnt + ADDR_W'(1) : cnt - ADDR_W'(1);
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/viterbi_ctrl.sv
// Frame sequencer for the hard-decision Viterbi datapath: metric clear,
// per-symbol ACS/survivor writes, then a newest-to-oldest traceback walk.
//
//   state | meaning
//   IDLE  | waiting for i_start
//   CLEAR | path metrics cleared, step counter reset
//   ACS   | accepting symbols, one ACS update + survivor write per handshake
//   TRACE | walking survivor read addresses FRAME_LEN-1 down to 0
//   DONE  | one-cycle end-of-frame pulse
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = VIT_FRAME_LEN,
  parameter int SIZE_DATA = VIT_SIZE_DATA,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_valid,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic                 o_ready,
  output logic [SIZE_DATA-1:0] o_sym,
  output logic                 o_pm_clear,
  output logic                 o_acs_en,
  output logic                 o_sm_we,
  output logic [ADDR_W-1:0]    o_sm_waddr,
  output logic                 o_tb_en,
  output logic                 o_tb_first,
  output logic [ADDR_W-1:0]    o_tb_raddr,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(FRAME_LEN - 1);

  vit_state_t        state, state_nxt;
  logic              hs;
  logic              step_load, step_en, step_tc;
  logic              tb_load, tb_cnt_en, tb_tc;
  logic [ADDR_W-1:0] step_cnt, tb_cnt;

  assign hs    = (state == ACS) && i_valid;
  assign o_sym = i_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = CLEAR;
      CLEAR:   state_nxt = ACS;
      ACS:     if (hs && step_tc) state_nxt = TRACE;
      TRACE:   if (tb_tc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready    = 1'b0;
    o_pm_clear = 1'b0;
    o_acs_en   = 1'b0;
    o_sm_we    = 1'b0;
    o_sm_waddr = '0;
    o_tb_en    = 1'b0;
    o_tb_first = 1'b0;
    o_tb_raddr = '0;
    o_done     = 1'b0;
    o_busy     = (state != IDLE);
    step_load  = 1'b0;
    step_en    = 1'b0;
    tb_load    = 1'b0;
    tb_cnt_en  = 1'b0;
    case (state)
      CLEAR: begin
        o_pm_clear = 1'b1;
        step_load  = 1'b1;
      end
      ACS: begin
        o_ready = 1'b1;
        if (hs) begin
          o_acs_en   = 1'b1;
          o_sm_we    = 1'b1;
          o_sm_waddr = step_cnt;
          step_en    = 1'b1;
          tb_load    = step_tc;
        end
      end
      TRACE: begin
        o_tb_en    = 1'b1;
        o_tb_raddr = tb_cnt;
        o_tb_first = (tb_cnt == LAST_STEP);
        tb_cnt_en  = 1'b1;
      end
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  viterbi_step_cnt #(.ADDR_W(ADDR_W)) u_step_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (step_load),
    .load_val ('0),
    .en       (step_en),
    .up       (1'b1),
    .term     (LAST_STEP),
    .cnt      (step_cnt),
    .tc       (step_tc)
  );

  // Traceback counter is preloaded on the final handshake and counts down to 0.
  viterbi_step_cnt #(.ADDR_W(ADDR_W)) u_tb_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (tb_load),
    .load_val (LAST_STEP),
    .en       (tb_cnt_en),
    .up       (1'b0),
    .term     ('0),
    .cnt      (tb_cnt),
    .tc       (tb_tc)
  );

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Bench for viterbi_ctrl: a 16-step and a 2-step instance share stimulus and
// are checked every cycle against a count-based frame model.
module tb_viterbi_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, valid;
  logic [1:0] data;

  always #5 clk = ~clk;

  logic       rdy0, clr0, acs0, we0, tb0, first0, busy0, done0;
  logic [1:0] sym0;
  logic [3:0] wa0, ra0;
  logic       rdy1, clr1, acs1, we1, tb1, first1, busy1, done1;
  logic [1:0] sym1;
  logic [0:0] wa1, ra1;

  viterbi_ctrl #(.FRAME_LEN(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid), .i_data(data),
    .o_ready(rdy0), .o_sym(sym0), .o_pm_clear(clr0), .o_acs_en(acs0), .o_sm_we(we0),
    .o_sm_waddr(wa0), .o_tb_en(tb0), .o_tb_first(first0), .o_tb_raddr(ra0),
    .o_busy(busy0), .o_done(done0)
  );

  viterbi_ctrl #(.FRAME_LEN(2)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid), .i_data(data),
    .o_ready(rdy1), .o_sym(sym1), .o_pm_clear(clr1), .o_acs_en(acs1), .o_sm_we(we1),
    .o_sm_waddr(wa1), .o_tb_en(tb1), .o_tb_first(first1), .o_tb_raddr(ra1),
    .o_busy(busy1), .o_done(done1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Frame model: active flag, clear seen, writes made, traceback steps made.
  int fl[2] = '{16, 2};
  int m_act[2], m_clr[2], m_w[2], m_t[2];
  bit s_clr[2], s_we[2], s_tb[2], s_done[2];
  int last_done[2];
  bit b2b = 1'b0;
  int n_b2b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    logic       e_clr, e_rdy, e_we, e_tb, e_first, e_done;
    logic [7:0] o_ctl, e_ctl;
    logic [31:0] o_wa, o_ra, o_sym;
    logic       o_clr, o_done;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) m_act[d] = 0;
      e_clr   = (m_act[d] != 0) && (m_clr[d] == 0);
      e_rdy   = (m_act[d] != 0) && (m_clr[d] != 0) && (m_w[d] < fl[d]);
      e_we    = e_rdy && valid;
      e_tb    = (m_act[d] != 0) && (m_w[d] == fl[d]) && (m_t[d] < fl[d]);
      e_first = e_tb && (m_t[d] == 0);
      e_done  = (m_act[d] != 0) && (m_t[d] == fl[d]);
      e_ctl   = {e_clr, e_rdy, e_we, e_we, e_tb, e_first, (m_act[d] != 0), e_done};
      if (d == 0) begin
        o_ctl = {clr0, rdy0, acs0, we0, tb0, first0, busy0, done0};
        o_wa = 32'(wa0); o_ra = 32'(ra0); o_sym = 32'(sym0);
        o_clr = clr0; o_done = done0;
      end else begin
        o_ctl = {clr1, rdy1, acs1, we1, tb1, first1, busy1, done1};
        o_wa = 32'(wa1); o_ra = 32'(ra1); o_sym = 32'(sym1);
        o_clr = clr1; o_done = done1;
      end
      chk($sformatf("ctl_fl%0d", fl[d]), 32'(o_ctl), 32'(e_ctl));
      chk($sformatf("sym_fl%0d", fl[d]), o_sym, 32'(data));
      if (e_we || !rst_n) chk($sformatf("waddr_fl%0d", fl[d]), o_wa, e_we ? m_w[d] : 0);
      if (e_tb || !rst_n) chk($sformatf("raddr_fl%0d", fl[d]), o_ra, e_tb ? fl[d] - 1 - m_t[d] : 0);
      if (b2b && o_clr && last_done[d] >= 0) begin
        chk($sformatf("b2b_gap_fl%0d", fl[d]), cyc - last_done[d], 2);
        n_b2b++;
        last_done[d] = -1;
      end
      if (o_done) last_done[d] = cyc;
      s_clr[d] = e_clr; s_we[d] = e_we; s_tb[d] = e_tb; s_done[d] = e_done;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst_n) begin
        if (m_act[d] == 0) begin
          if (start) begin
            m_act[d] = 1; m_clr[d] = 0; m_w[d] = 0; m_t[d] = 0;
          end
        end else begin
          if (s_clr[d])  m_clr[d] = 1;
          if (s_we[d])   m_w[d]++;
          if (s_tb[d])   m_t[d]++;
          if (s_done[d]) m_act[d] = 0;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int i;
    start = 1'b0;
    for (i = 0; i < 100; i++) begin
      if (m_act[0] == 0 && m_act[1] == 0) break;
      valid = 1'($urandom_range(0, 1));
      data  = 2'($urandom);
      step();
    end
    chk("drain_timeout", 32'(i < 100), 32'd1);
  endtask

  initial begin
    int t0;
    int i;
    logic [3:0] pat;
    pat = 4'b1001;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_clr[d] = 0; m_w[d] = 0; m_t[d] = 0; last_done[d] = -1;
    end
    rst_n = 1'b0; start = 1'b1; valid = 1'b1; data = 2'b00;
    @(negedge clk);
    repeat (3) begin data = 2'($urandom); step(); end
    rst_n = 1'b1; start = 1'b0;
    repeat (4) begin data = 2'($urandom); step(); end

    // Nominal frame, no stalls
    start = 1'b1; t0 = cyc; step();
    start = 1'b0; valid = 1'b1;
    for (i = 0; i < 60; i++) begin
      if (last_done[0] >= t0) break;
      data = 2'($urandom); step();
    end
    chk("nominal_timeout", 32'(last_done[0] >= t0), 32'd1);
    chk("frame_cycles", 32'(last_done[0] - t0 + 1), 32'd35);
    drain();

    // Stall pattern 1,0,0,1 with stray i_start pulses while busy
    start = 1'b1; step(); start = 1'b0;
    for (i = 0; i < 200; i++) begin
      if (m_act[0] == 0) break;
      valid = pat[i % 4];
      start = ($urandom_range(0, 3) == 0);
      data  = 2'($urandom);
      step();
    end
    chk("stall_timeout", 32'(i < 200), 32'd1);
    drain();

    // Random valid traffic
    repeat (3) begin
      start = 1'b1; step(); start = 1'b0;
      for (i = 0; i < 300; i++) begin
        if (m_act[0] == 0) break;
        valid = 1'($urandom_range(0, 1));
        start = ($urandom_range(0, 7) == 0);
        data  = 2'($urandom);
        step();
      end
      chk("random_timeout", 32'(i < 300), 32'd1);
      drain();
    end

    // Reset at ACS step 7, then a clean frame
    start = 1'b1; step(); start = 1'b0; valid = 1'b1;
    for (i = 0; i < 20; i++) begin
      if (m_w[0] == 7) break;
      data = 2'($urandom); step();
    end
    chk("reach_step7", 32'(m_w[0]), 32'd7);
    rst_n = 1'b0; step(); step();
    rst_n = 1'b1; step();
    start = 1'b1; t0 = cyc; step(); start = 1'b0; valid = 1'b1;
    for (i = 0; i < 60; i++) begin
      if (last_done[0] >= t0) break;
      data = 2'($urandom); step();
    end
    chk("post_reset_frame", 32'(last_done[0] - t0 + 1), 32'd35);
    drain();

    // Back-to-back frames with i_start held
    b2b = 1'b1; last_done[0] = -1; last_done[1] = -1;
    start = 1'b1; valid = 1'b1;
    repeat (90) begin data = 2'($urandom); step(); end
    chk("b2b_seen", 32'(n_b2b >= 4), 32'd1);
    b2b = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
